inst_fetch_arbiter: RTL and testbench

INST_FETCH_ARBITER -- requirements
Module: inst_fetch_arbiter

---
 rtl/inst_fetch_arbiter.sv | 109 ++++++++++
 tb/tb_inst_fetch_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_arbiter.sv
// Instruction fetch arbiter: shares one instruction memory port between two fetch ways.
// Round-robin arbitration on ties, a single outstanding memory transaction, and flush
// support that drains a cancelled fetch without returning data to the requester.
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   wayN_request_i / wayN_instAddr_i   fetch request and address from way N
//   wayN_flush_i                       cancel way N's outstanding fetch
//   wayN_inst_o / wayN_dataOk_o        returned instruction and its valid strobe
//   mem_request_o / mem_instAddr_o     request and address to shared memory
//   mem_inst_i / mem_dataOk_i          instruction and valid strobe from memory
module inst_fetch_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              way0_request_i,
  input  logic [ADDR_W-1:0] way0_instAddr_i,
  input  logic              way0_flush_i,
  output logic [INST_W-1:0] way0_inst_o,
  output logic              way0_dataOk_o,
  input  logic              way1_request_i,
  input  logic [ADDR_W-1:0] way1_instAddr_i,
  input  logic              way1_flush_i,
  output logic [INST_W-1:0] way1_inst_o,
  output logic              way1_dataOk_o,
  output logic              mem_request_o,
  output logic [ADDR_W-1:0] mem_instAddr_o,
  input  logic [INST_W-1:0] mem_inst_i,
  input  logic              mem_dataOk_i
);

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic sel;
  logic gnt_flush;

  // Winner of arbitration in IDLE: on a tie, the way that did not win last time.
  always_comb begin
    if (way0_request_i && way1_request_i) begin
      sel = ~last_q;
    end else begin
      sel = ~way0_request_i;
    end
  end

  assign gnt_flush = grant_q ? way1_flush_i : way0_flush_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        if (way0_request_i || way1_request_i) begin
          state_d = StWait;
          grant_d = sel;
          last_d  = sel;
          addr_d  = sel ? way1_instAddr_i : way0_instAddr_i;
        end
      end
      StWait: begin
        // Data arriving wins over a coincident flush: the transaction is complete either way.
        if (mem_dataOk_i) begin
          state_d = StIdle;
        end else if (gnt_flush) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (mem_dataOk_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_request_o  = (state_q != StIdle);
  assign mem_instAddr_o = addr_q;

  assign way0_dataOk_o = (state_q == StWait) && !grant_q && mem_dataOk_i && !way0_flush_i;
  assign way1_dataOk_o = (state_q == StWait) && grant_q && mem_dataOk_i && !way1_flush_i;

  assign way0_inst_o = mem_inst_i;
  assign way1_inst_o = mem_inst_i;

endmodule

// File: tb/tb_inst_fetch_arbiter.sv
module tb_inst_fetch_arbiter;
  localparam int AW   = 32;
  localparam int IW   = 32;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          way0_request_i, way1_request_i;
  logic [AW-1:0] way0_instAddr_i, way1_instAddr_i;
  logic          way0_flush_i, way1_flush_i;
  logic [IW-1:0] way0_inst_o, way1_inst_o;
  logic          way0_dataOk_o, way1_dataOk_o;
  logic          mem_request_o;
  logic [AW-1:0] mem_instAddr_o;
  logic [IW-1:0] mem_inst_i;
  logic          mem_dataOk_i;

  inst_fetch_arbiter #(.ADDR_W(AW), .INST_W(IW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .way0_request_i  (way0_request_i),
    .way0_instAddr_i (way0_instAddr_i),
    .way0_flush_i    (way0_flush_i),
    .way0_inst_o     (way0_inst_o),
    .way0_dataOk_o   (way0_dataOk_o),
    .way1_request_i  (way1_request_i),
    .way1_instAddr_i (way1_instAddr_i),
    .way1_flush_i    (way1_flush_i),
    .way1_inst_o     (way1_inst_o),
    .way1_dataOk_o   (way1_dataOk_o),
    .mem_request_o   (mem_request_o),
    .mem_instAddr_o  (mem_instAddr_o),
    .mem_inst_i      (mem_inst_i),
    .mem_dataOk_i    (mem_dataOk_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        req;
    logic [AW-1:0] addr;
  } mem_ev_t;

  typedef struct {
    int          cyc;
    logic [IW-1:0] data;
  } ok_ev_t;

  mem_ev_t mem_q[$];
  ok_ev_t  ok0_q[$];
  ok_ev_t  ok1_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  // Requester behaviour: a pending fetch is held until delivered or flushed.
  logic          pend[2];
  logic [AW-1:0] raddr[2];
  logic          flush_c[2];

  // Transaction-level reference: one fetch in flight, owner, cancelled flag, tie preference.
  logic          m_busy, m_way, m_cancel, m_pref;
  logic [AW-1:0] m_addr;

  task automatic check1(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic do_cycle();
    logic          mok, ok0, ok1, win;
    logic [IW-1:0] mi;
    cyc++;
    for (int x = 0; x < 2; x++) begin
      if (!pend[x] && $urandom_range(99) < 30) begin
        pend[x]  = 1'b1;
        raddr[x] = $urandom & 32'hffff_fffc;
      end else if (pend[x] && $urandom_range(99) < 5) begin
        raddr[x] = $urandom & 32'hffff_fffc;
      end
      flush_c[x] = ($urandom_range(99) < 8);
    end
    mok = ($urandom_range(99) < 35);
    mi  = $urandom;

    way0_request_i  = pend[0];
    way1_request_i  = pend[1];
    way0_instAddr_i = raddr[0];
    way1_instAddr_i = raddr[1];
    way0_flush_i    = flush_c[0];
    way1_flush_i    = flush_c[1];
    mem_dataOk_i    = mok;
    mem_inst_i      = mi;

    mem_q.push_back(mem_ev_t'{cyc, m_busy, m_addr});
    ok0 = m_busy && !m_cancel && (m_way == 1'b0) && mok && !flush_c[0];
    ok1 = m_busy && !m_cancel && (m_way == 1'b1) && mok && !flush_c[1];
    if (ok0) ok0_q.push_back(ok_ev_t'{cyc, mi});
    if (ok1) ok1_q.push_back(ok_ev_t'{cyc, mi});

    if (m_busy) begin
      if (mok) begin
        m_busy   = 1'b0;
        m_cancel = 1'b0;
      end else if (flush_c[m_way]) begin
        m_cancel = 1'b1;
      end
    end else if (pend[0] || pend[1]) begin
      win      = (pend[0] && pend[1]) ? m_pref : !pend[0];
      m_busy   = 1'b1;
      m_way    = win;
      m_addr   = raddr[win];
      m_cancel = 1'b0;
      m_pref   = !win;
    end

    if (ok0 || flush_c[0]) pend[0] = 1'b0;
    if (ok1 || flush_c[1]) pend[1] = 1'b0;
  endtask

  // Monitor: compares DUT outputs against queued expectations each cycle.
  initial begin
    mem_ev_t me;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (mem_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL mem_expect cyc=%0d actual=no_entry required=entry", cyc);
        end else begin
          me = mem_q.pop_front();
          check1("mem_seq", 64'(me.cyc), 64'(cyc));
          check1("mem_request", 64'(mem_request_o), 64'(me.req));
          check1("mem_addr", 64'(mem_instAddr_o), 64'(me.addr));
        end
        if (way0_dataOk_o || (ok0_q.size() > 0 && ok0_q[0].cyc == cyc)) begin
          checks++;
          if (!way0_dataOk_o || ok0_q.size() == 0 || ok0_q[0].cyc != cyc ||
              way0_inst_o !== ok0_q[0].data) begin
            failures++;
            $display("FAIL way0_dataOk cyc=%0d actual=%0b/%0h required_pending=%0d",
                     cyc, way0_dataOk_o, way0_inst_o, ok0_q.size());
          end
          if (ok0_q.size() > 0 && ok0_q[0].cyc <= cyc) void'(ok0_q.pop_front());
        end
        if (way1_dataOk_o || (ok1_q.size() > 0 && ok1_q[0].cyc == cyc)) begin
          checks++;
          if (!way1_dataOk_o || ok1_q.size() == 0 || ok1_q[0].cyc != cyc ||
              way1_inst_o !== ok1_q[0].data) begin
            failures++;
            $display("FAIL way1_dataOk cyc=%0d actual=%0b/%0h required_pending=%0d",
                     cyc, way1_dataOk_o, way1_inst_o, ok1_q.size());
          end
          if (ok1_q.size() > 0 && ok1_q[0].cyc <= cyc) void'(ok1_q.pop_front());
        end
      end
    end
  end

  initial begin
    int guard;
    way0_request_i  = 1'b0;
    way1_request_i  = 1'b0;
    way0_instAddr_i = '0;
    way1_instAddr_i = '0;
    way0_flush_i    = 1'b0;
    way1_flush_i    = 1'b0;
    mem_inst_i      = '0;
    mem_dataOk_i    = 1'b1;
    for (int x = 0; x < 2; x++) begin
      pend[x]    = 1'b0;
      raddr[x]   = '0;
      flush_c[x] = 1'b0;
    end
    m_busy   = 1'b0;
    m_way    = 1'b0;
    m_cancel = 1'b0;
    m_pref   = 1'b0;
    m_addr   = '0;

    #1;
    check1("rst_mem_request", 64'(mem_request_o), 64'd0);
    check1("rst_mem_addr", 64'(mem_instAddr_o), 64'd0);
    check1("rst_way0_ok", 64'(way0_dataOk_o), 64'd0);
    check1("rst_way1_ok", 64'(way1_dataOk_o), 64'd0);

    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    do_cycle();
    repeat (NCYC) begin
      @(negedge clk);
      do_cycle();
    end

    // Run on until a live (uncancelled) fetch is in flight, then reset in the middle of it.
    guard = 0;
    while (!(m_busy && !m_cancel) && guard < 200) begin
      @(negedge clk);
      do_cycle();
      guard++;
    end
    if (!(m_busy && !m_cancel)) begin
      checks++;
      failures++;
      $display("FAIL reach_wait cyc=%0d actual=idle required=busy", cyc);
    end

    @(negedge clk);
    mon_en       = 1'b0;
    way0_flush_i = 1'b0;
    way1_flush_i = 1'b0;
    mem_dataOk_i = 1'b1;
    #1;
    check1("pre_rst_ok", 64'(m_way ? way1_dataOk_o : way0_dataOk_o), 64'd1);
    reset_n = 1'b0;
    #1;
    check1("mid_rst_mem_request", 64'(mem_request_o), 64'd0);
    check1("mid_rst_mem_addr", 64'(mem_instAddr_o), 64'd0);
    check1("mid_rst_way0_ok", 64'(way0_dataOk_o), 64'd0);
    check1("mid_rst_way1_ok", 64'(way1_dataOk_o), 64'd0);

    m_busy   = 1'b0;
    m_way    = 1'b0;
    m_cancel = 1'b0;
    m_pref   = 1'b0;
    m_addr   = '0;
    pend[0]  = 1'b1;
    pend[1]  = 1'b1;
    raddr[0] = 32'h100;
    raddr[1] = 32'h200;
    mem_q.delete();
    ok0_q.delete();
    ok1_q.delete();

    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    do_cycle();
    repeat (500) begin
      @(negedge clk);
      do_cycle();
    end
    @(negedge clk);
    mon_en = 1'b0;
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
